// File: rtl/pa_fpu.sv
`default_nettype none
// Shared fpu types: operation codes, host-sequencer states and the fpu register map.
package pa_fpu;

  typedef enum logic [2:0] {
    FPU_OP_ADD = 3'd0,
    FPU_OP_SUB = 3'd1,
    FPU_OP_MUL = 3'd2,
    FPU_OP_DIV = 3'd3
  } e_fpu_op;

  typedef enum logic [3:0] {
    SEQ_IDLE     = 4'd0,
    SEQ_WR_A     = 4'd1,
    SEQ_WR_B     = 4'd2,
    SEQ_WR_OP    = 4'd3,
    SEQ_START    = 4'd4,
    SEQ_WAIT_END = 4'd5,
    SEQ_RD       = 4'd6,
    SEQ_RD_END   = 4'd7,
    SEQ_ACK      = 4'd8,
    SEQ_RSP      = 4'd9
  } e_fpu_seq_state;

  localparam logic [3:0] FPU_ADDR_A     = 4'd0;
  localparam logic [3:0] FPU_ADDR_B     = 4'd4;
  localparam logic [3:0] FPU_ADDR_OP    = 4'd8;
  localparam logic [3:0] FPU_ADDR_START = 4'd9;
  localparam logic [3:0] FPU_ADDR_RES   = 4'd9;

  localparam logic [7:0] FPU_START_CMD  = 8'h01;

endpackage
`default_nettype wire

// File: rtl/fpu_bus_cycle.sv
`default_nettype none
// Single-byte fpu register-bus engine: 3-clock write (setup/strobe/hold) or 2-clock read,
// repeated back to back for as long as go_i is held.
module fpu_bus_cycle (
  input  logic       clk,
  input  logic       arst_n,
  input  logic       go_i,
  input  logic       read_i,
  input  logic [3:0] addr_i,
  input  logic [7:0] wdata_i,
  output logic       done_o,
  output logic       capture_o,
  output logic [3:0] addr_o,
  output logic [7:0] wdata_o,
  output logic       wr_n_o,
  output logic       rd_n_o
);

  localparam logic [1:0] PH_SETUP  = 2'd0;
  localparam logic [1:0] PH_STROBE = 2'd1;
  localparam logic [1:0] PH_HOLD   = 2'd2;

  logic [1:0] phase_q, phase_d;

  always_comb begin
    capture_o = go_i & read_i & (phase_q == PH_STROBE);
    done_o    = go_i & (read_i ? (phase_q == PH_STROBE) : (phase_q == PH_HOLD));
    phase_d   = (go_i & ~done_o) ? phase_q + 2'd1 : PH_SETUP;
    wr_n_o    = ~(go_i & ~read_i & (phase_q == PH_STROBE));
    // rd stays low across every clock of a read so the fpu output never floats mid-byte.
    rd_n_o    = ~(go_i & read_i);
    addr_o    = go_i ? addr_i : 4'd0;
    wdata_o   = (go_i & ~read_i) ? wdata_i : 8'd0;
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      phase_q <= PH_SETUP;
    end else begin
      phase_q <= phase_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fpu_host_sequencer.sv
`default_nettype none
// Host-side bus master for the fpu: takes one job on a valid/ready port, runs the register-bus
// write/start/wait/read/acknowledge sequence and returns the result or a timeout flag.
module fpu_host_sequencer
  import pa_fpu::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        arst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_op_a,
  input  logic [31:0] req_op_b,
  input  e_fpu_op     req_op,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic        rsp_timeout,
  output logic [7:0]  databus_out,
  input  logic [7:0]  databus_in,
  output logic [3:0]  addr,
  output logic        cs,
  output logic        rd,
  output logic        wr,
  output logic        end_ack,
  input  logic        cmd_end,
  input  logic        busy
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  e_fpu_seq_state   state_q, state_d;
  logic [1:0]       byte_q, byte_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [31:0]      op_a_q, op_b_q;
  e_fpu_op          op_q;
  logic [31:0]      result_q, result_d;
  logic             timeout_q, timeout_d;
  logic             load;
  logic             tmo_expired;

  logic             bus_go, bus_read, bus_done, bus_capture;
  logic [3:0]       bus_addr;
  logic [7:0]       bus_wdata;

  assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    state_d   = state_q;
    byte_d    = byte_q;
    tmo_d     = tmo_q;
    result_d  = result_q;
    timeout_d = timeout_q;
    load      = 1'b0;
    bus_go    = 1'b0;
    bus_read  = 1'b0;
    bus_addr  = 4'd0;
    bus_wdata = 8'd0;
    cs        = 1'b1;
    end_ack   = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;

    case (state_q)
      SEQ_IDLE: begin
        // Gated with reset so the port reads not-ready while the block is held in reset.
        req_ready = ~busy & arst_n;
        if (req_valid && !busy) begin
          load      = 1'b1;
          result_d  = 32'd0;
          timeout_d = 1'b0;
          byte_d    = 2'd0;
          state_d   = SEQ_WR_A;
        end
      end
      SEQ_WR_A, SEQ_WR_B: begin
        bus_go    = 1'b1;
        cs        = 1'b0;
        bus_addr  = ((state_q == SEQ_WR_A) ? FPU_ADDR_A : FPU_ADDR_B) + {2'b00, byte_q};
        bus_wdata = (state_q == SEQ_WR_A) ? op_a_q[8*byte_q +: 8] : op_b_q[8*byte_q +: 8];
        if (bus_done) begin
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = (state_q == SEQ_WR_A) ? SEQ_WR_B : SEQ_WR_OP;
        end
      end
      SEQ_WR_OP: begin
        bus_go    = 1'b1;
        cs        = 1'b0;
        bus_addr  = FPU_ADDR_OP;
        bus_wdata = {5'd0, op_q};
        if (bus_done) state_d = SEQ_START;
      end
      SEQ_START: begin
        bus_go    = 1'b1;
        cs        = 1'b0;
        bus_addr  = FPU_ADDR_START;
        bus_wdata = FPU_START_CMD;
        if (bus_done) begin
          tmo_d   = '0;
          state_d = SEQ_WAIT_END;
        end
      end
      SEQ_WAIT_END: begin
        if (cmd_end) begin
          byte_d  = 2'd0;
          state_d = SEQ_RD;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          result_d  = 32'd0;
          state_d   = SEQ_RSP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SEQ_RD: begin
        bus_go   = 1'b1;
        bus_read = 1'b1;
        cs       = 1'b0;
        bus_addr = FPU_ADDR_RES + {2'b00, byte_q};
        if (bus_capture) result_d[8*byte_q +: 8] = databus_in;
        if (bus_done) begin
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) state_d = SEQ_RD_END;
        end
      end
      SEQ_RD_END: begin
        cs      = 1'b0;
        tmo_d   = '0;
        state_d = SEQ_ACK;
      end
      SEQ_ACK: begin
        end_ack = 1'b1;
        if (!cmd_end) begin
          state_d = SEQ_RSP;
        end else if (tmo_expired) begin
          timeout_d = 1'b1;
          result_d  = 32'd0;
          state_d   = SEQ_RSP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      SEQ_RSP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = SEQ_IDLE;
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      state_q   <= SEQ_IDLE;
      byte_q    <= 2'd0;
      tmo_q     <= '0;
      op_a_q    <= 32'd0;
      op_b_q    <= 32'd0;
      op_q      <= FPU_OP_ADD;
      result_q  <= 32'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      byte_q    <= byte_d;
      tmo_q     <= tmo_d;
      result_q  <= result_d;
      timeout_q <= timeout_d;
      if (load) begin
        op_a_q <= req_op_a;
        op_b_q <= req_op_b;
        op_q   <= req_op;
      end
    end
  end

  assign rsp_result  = result_q;
  assign rsp_timeout = timeout_q;

  fpu_bus_cycle u_bus_cycle (
    .clk       (clk),
    .arst_n    (arst_n),
    .go_i      (bus_go),
    .read_i    (bus_read),
    .addr_i    (bus_addr),
    .wdata_i   (bus_wdata),
    .done_o    (bus_done),
    .capture_o (bus_capture),
    .addr_o    (addr),
    .wdata_o   (databus_out),
    .wr_n_o    (wr),
    .rd_n_o    (rd)
  );

endmodule
`default_nettype wire
